// File: rtl/noc_local_injector_pkg.sv
// Shared types for the local-port flit injector: flit layouts, flit types and FSM states.
// Flit width is sized so a BODY/TAIL flit carries a full payload word behind its type field.
package noc_local_injector_pkg;

    localparam int Noc_VC_Channel = 4;
    localparam int Noc_ID_X_Width = 4;
    localparam int Noc_ID_Y_Width = 4;
    localparam int Noc_Payload_W  = 32;
    localparam int Noc_Len_W      = 4;
    localparam int Noc_Flit_Width = 2 + Noc_Payload_W;
    localparam int Noc_Head_Pad_W = Noc_Flit_Width - 2 - 2 * Noc_ID_X_Width
                                    - 2 * Noc_ID_Y_Width - Noc_Len_W;

    typedef enum logic [1:0] {
        FLIT_HEAD     = 2'd0,
        FLIT_BODY     = 2'd1,
        FLIT_TAIL     = 2'd2,
        FLIT_HEADTAIL = 2'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e                ftype;
        logic [Noc_ID_X_Width-1:0] dst_x;
        logic [Noc_ID_Y_Width-1:0] dst_y;
        logic [Noc_ID_X_Width-1:0] src_x;
        logic [Noc_ID_Y_Width-1:0] src_y;
        logic [Noc_Len_W-1:0]      len;
        logic [Noc_Head_Pad_W-1:0] pad;
    } head_flit_t;

    typedef struct packed {
        flit_type_e               ftype;
        logic [Noc_Payload_W-1:0] payload;
    } body_flit_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_HEAD  = 2'd2,
        ST_BODY  = 2'd3
    } inj_state_e;

endpackage

// File: rtl/noc_rr_vc_arbiter.sv
// Round-robin VC picker: grants the first requesting VC at or after ptr, wrapping around.
// Purely combinational; the caller owns and advances the pointer.
module noc_rr_vc_arbiter #(
    parameter int CHANNELS = 4,
    parameter int VC_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [VC_W-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [VC_W-1:0]     grant_idx,
    output logic                grant_valid
);

    logic [VC_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = VC_W'((int'(ptr) + i) % CHANNELS);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/noc_local_injector.sv
// Local-port network-interface transmitter: turns a (dst, len) request plus a payload stream
// into HEAD/BODY/TAIL flits on one round-robin-allocated VC with a registered output stage.
module noc_local_injector
    import noc_local_injector_pkg::*;
#(
    parameter int CHANNELS  = Noc_VC_Channel,
    parameter int PAYLOAD_W = Noc_Payload_W,
    parameter int LEN_W     = Noc_Len_W
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic [Noc_ID_X_Width-1:0] id_x,
    input  logic [Noc_ID_Y_Width-1:0] id_y,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [Noc_ID_X_Width-1:0] req_dst_x,
    input  logic [Noc_ID_Y_Width-1:0] req_dst_y,
    input  logic [LEN_W-1:0]          req_len,
    input  logic                      pay_valid,
    output logic                      pay_ready,
    input  logic [PAYLOAD_W-1:0]      pay_data,
    output logic [CHANNELS-1:0]       tx_valid,
    output logic [Noc_Flit_Width-1:0] tx_flit,
    input  logic [CHANNELS-1:0]       tx_ready,
    input  logic [CHANNELS-1:0]       tx_vc_ready,
    output logic                      busy
);

    localparam int VC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    inj_state_e                state;
    logic [Noc_ID_X_Width-1:0] dst_x_q;
    logic [Noc_ID_Y_Width-1:0] dst_y_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          len_cnt;
    logic [VC_W-1:0]           vc;
    logic [CHANNELS-1:0]       vc_sel;
    logic [VC_W-1:0]           rr_ptr;

    logic [CHANNELS-1:0]       grant;
    logic [VC_W-1:0]           grant_idx;
    logic                      grant_valid;

    logic                      out_valid;
    logic                      out_fire;
    logic                      req_fire;
    logic                      pay_fire;
    head_flit_t                head_flit;
    body_flit_t                body_flit;

    noc_rr_vc_arbiter #(
        .CHANNELS (CHANNELS),
        .VC_W     (VC_W)
    ) u_arbiter (
        .req         (tx_vc_ready),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign out_valid = |tx_valid;
    assign out_fire  = out_valid && tx_ready[vc];
    assign req_ready = (state == ST_IDLE);
    assign req_fire  = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);
    // A new payload word may enter whenever the output slot is empty or drains this cycle.
    assign pay_ready = (state == ST_BODY) && (len_cnt != '0) && (!out_valid || tx_ready[vc]);
    assign pay_fire  = pay_valid && pay_ready;

    always_comb begin
        head_flit.ftype   = (len_q == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
        head_flit.dst_x   = dst_x_q;
        head_flit.dst_y   = dst_y_q;
        head_flit.src_x   = id_x;
        head_flit.src_y   = id_y;
        head_flit.len     = Noc_Len_W'(len_q);
        head_flit.pad     = '0;
        body_flit.ftype   = (len_cnt == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
        body_flit.payload = Noc_Payload_W'(pay_data);
    end

    // Moving to BODY as soon as the HEAD is loaded lets the first payload word
    // replace the HEAD in the same cycle it fires, so flits stream back to back.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state   <= ST_IDLE;
            tx_valid <= '0;
            tx_flit <= '0;
            rr_ptr  <= '0;
            len_cnt <= '0;
            len_q   <= '0;
            dst_x_q <= '0;
            dst_y_q <= '0;
            vc      <= '0;
            vc_sel  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        dst_x_q <= req_dst_x;
                        dst_y_q <= req_dst_y;
                        len_q   <= req_len;
                        len_cnt <= req_len;
                        state   <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (grant_valid) begin
                        vc     <= grant_idx;
                        vc_sel <= grant;
                        rr_ptr <= (grant_idx == VC_W'(CHANNELS - 1)) ? '0 : grant_idx + VC_W'(1);
                        state  <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (!out_valid) begin
                        tx_flit  <= head_flit;
                        tx_valid <= vc_sel;
                        if (len_q != '0) begin
                            state <= ST_BODY;
                        end
                    end else if (out_fire) begin
                        tx_valid <= '0;
                        state    <= ST_IDLE;
                    end
                end
                ST_BODY: begin
                    if (pay_fire) begin
                        tx_flit  <= body_flit;
                        tx_valid <= vc_sel;
                        len_cnt  <= len_cnt - LEN_W'(1);
                    end else if (out_fire) begin
                        tx_valid <= '0;
                        if (len_cnt == '0) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_local_injector.sv
// Self-checking bench for noc_local_injector: table-driven packets, randomized packets
// checked against a flit-list/round-robin model, and a hand-written mid-packet reset.
module tb_noc_local_injector;

    localparam int CH = 4;
    localparam int PW = 32;
    localparam int LW = 4;
    localparam int FW = 34;
    localparam logic [3:0] ID_X = 4'd5;
    localparam logic [3:0] ID_Y = 4'd9;

    logic          noc_clk = 1'b0;
    logic          noc_rst_n;
    logic [3:0]    id_x;
    logic [3:0]    id_y;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_dst_x;
    logic [3:0]    req_dst_y;
    logic [LW-1:0] req_len;
    logic          pay_valid;
    logic          pay_ready;
    logic [PW-1:0] pay_data;
    logic [CH-1:0] tx_valid;
    logic [FW-1:0] tx_flit;
    logic [CH-1:0] tx_ready;
    logic [CH-1:0] tx_vc_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int model_ptr = 0;

    typedef struct {
        logic [3:0] dx;
        logic [3:0] dy;
        int         len;
        logic [3:0] vcr;
        int         ready_pct;
        int         pay_pct;
        int         alloc_delay;
        int         exp_vc;
    } vec_t;

    noc_local_injector dut (
        .noc_clk     (noc_clk),
        .noc_rst_n   (noc_rst_n),
        .id_x        (id_x),
        .id_y        (id_y),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dst_x   (req_dst_x),
        .req_dst_y   (req_dst_y),
        .req_len     (req_len),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .pay_data    (pay_data),
        .tx_valid    (tx_valid),
        .tx_flit     (tx_flit),
        .tx_ready    (tx_ready),
        .tx_vc_ready (tx_vc_ready),
        .busy        (busy)
    );

    always #5 noc_clk = ~noc_clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Round-robin reference: first free VC at or after the model pointer, wrapping.
    function automatic int pick_vc(input logic [3:0] vcr);
        for (int i = 0; i < CH; i++) begin
            int c;
            c = (model_ptr + i) % CH;
            if (vcr[c]) return c;
        end
        return 0;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        logic [FW-1:0] exp_q[$];
        logic [PW-1:0] pay_q[$];
        logic [PW-1:0] d;
        logic [CH-1:0] exp_oh;
        logic [CH-1:0] prev_valid;
        logic [FW-1:0] prev_flit;
        logic          prev_stall;
        logic          sent;
        int            vc;
        int            got;
        int            pidx;
        int            cyc;
        int            r;
        int            first_valid;
        int            last_fire;

        prev_stall  = 1'b0;
        prev_valid  = '0;
        prev_flit   = '0;
        sent        = 1'b0;
        got         = 0;
        pidx        = 0;
        cyc         = 0;
        r           = -1;
        first_valid = -1;
        last_fire   = -1;

        vc        = (v.exp_vc >= 0) ? v.exp_vc : pick_vc(v.vcr);
        model_ptr = (vc + 1) % CH;
        exp_oh    = 4'b0001 << vc;

        exp_q.push_back({(v.len == 0) ? 2'b11 : 2'b00, v.dx, v.dy, ID_X, ID_Y, LW'(v.len), 12'h000});
        for (int i = 0; i < v.len; i++) begin
            d = $urandom;
            pay_q.push_back(d);
            exp_q.push_back({(i == v.len - 1) ? 2'b10 : 2'b01, d});
        end

        while (got < v.len + 1 && cyc < 400) begin
            @(negedge noc_clk);
            req_valid = !sent;
            req_dst_x = v.dx;
            req_dst_y = v.dy;
            req_len   = LW'(v.len);
            if (!sent)
                tx_vc_ready = v.vcr;
            else if (cyc <= r + v.alloc_delay)
                tx_vc_ready = '0;
            else if (cyc == r + 1 + v.alloc_delay)
                tx_vc_ready = v.vcr;
            else
                tx_vc_ready = 4'($urandom);
            for (int b = 0; b < CH; b++)
                tx_ready[b] = (int'($urandom_range(99)) < v.ready_pct);
            pay_valid = (int'($urandom_range(99)) < v.pay_pct);
            pay_data  = (pidx < v.len) ? pay_q[pidx] : PW'($urandom);
            #1;

            if (!sent) begin
                check_output("pay_ready_idle", pay_ready, 1'b0);
                if (req_ready) begin
                    sent = 1'b1;
                    r    = cyc;
                end
            end else if (cyc > r) begin
                check_output("busy_in_packet", busy, 1'b1);
                check_output("req_ready_in_packet", req_ready, 1'b0);
                if (cyc <= r + 2 + v.alloc_delay)
                    check_output("tx_valid_before_head", tx_valid, '0);
            end

            if (prev_stall) begin
                check_output("stall_flit_stable", tx_flit, prev_flit);
                check_output("stall_valid_stable", tx_valid, prev_valid);
            end
            check_output("tx_valid_onehot", ($countones(tx_valid) <= 1), 1'b1);
            check_output("pay_ready_limit", (pay_ready && pidx >= v.len), 1'b0);
            if (first_valid < 0 && |tx_valid) first_valid = cyc;

            if (pay_valid && pay_ready && pidx < v.len) pidx++;

            if (|(tx_valid & tx_ready)) begin
                check_output("flit_vc", tx_valid, exp_oh);
                check_output("flit_data", tx_flit, exp_q[got]);
                if (v.ready_pct == 100 && v.pay_pct == 100 && last_fire >= 0)
                    check_output("back_to_back", cyc - last_fire, 1);
                last_fire  = cyc;
                got++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = |tx_valid;
            end
            prev_flit  = tx_flit;
            prev_valid = tx_valid;
            cyc++;
        end

        if (got < v.len + 1) check_output("packet_timeout", got, v.len + 1);
        if (first_valid >= 0 && r >= 0)
            check_output("head_latency", first_valid - r, 3 + v.alloc_delay);

        @(negedge noc_clk);
        req_valid = 1'b0;
        pay_valid = 1'b0;
        tx_ready  = '0;
        #1;
        check_output("idle_req_ready", req_ready, 1'b1);
        check_output("idle_busy", busy, 1'b0);
        check_output("idle_tx_valid", tx_valid, '0);
    endtask

    initial begin
        vec_t tbl[11];
        vec_t rv;

        tbl[0]  = '{4'd3,  4'd0,  1,  4'b1111, 100, 100, 0,  0};
        tbl[1]  = '{4'd1,  4'd2,  2,  4'b1111, 100, 100, 0,  1};
        tbl[2]  = '{4'd0,  4'd3,  0,  4'b1111, 100, 100, 0,  2};
        tbl[3]  = '{4'd7,  4'd7,  1,  4'b0001, 100, 100, 0,  0};
        tbl[4]  = '{4'd2,  4'd1,  0,  4'b0001, 100, 100, 0,  0};
        tbl[5]  = '{4'd4,  4'd5,  3,  4'b1111, 100, 100, 0,  1};
        tbl[6]  = '{4'd6,  4'd2,  5,  4'b0100, 50,  60,  0,  2};
        tbl[7]  = '{4'd1,  4'd1,  2,  4'b1000, 80,  80,  10, 3};
        tbl[8]  = '{4'd15, 4'd15, 15, 4'b0110, 100, 100, 0,  1};
        tbl[9]  = '{4'd9,  4'd3,  15, 4'b0011, 40,  70,  0,  0};
        tbl[10] = '{4'd2,  4'd2,  4,  4'b1111, 100, 100, 0,  0};

        noc_rst_n   = 1'b0;
        id_x        = ID_X;
        id_y        = ID_Y;
        req_valid   = 1'b0;
        req_dst_x   = '0;
        req_dst_y   = '0;
        req_len     = '0;
        pay_valid   = 1'b0;
        pay_data    = '0;
        tx_ready    = '0;
        tx_vc_ready = '0;
        #1;
        check_output("reset_tx_valid", tx_valid, '0);
        check_output("reset_tx_flit", tx_flit, '0);
        check_output("reset_busy", busy, 1'b0);
        repeat (3) @(negedge noc_clk);
        noc_rst_n = 1'b1;
        #1;
        check_output("post_reset_req_ready", req_ready, 1'b1);
        check_output("post_reset_pay_ready", pay_ready, 1'b0);

        for (int i = 0; i < 10; i++) begin
            $display("[TB] table packet %0d", i);
            apply_stimulus(tbl[i]);
        end

        for (int i = 0; i < 25; i++) begin
            rv.dx          = 4'($urandom);
            rv.dy          = 4'($urandom);
            rv.len         = int'($urandom_range(15));
            rv.vcr         = 4'($urandom_range(15, 1));
            rv.ready_pct   = int'($urandom_range(100, 40));
            rv.pay_pct     = int'($urandom_range(100, 40));
            rv.alloc_delay = int'($urandom_range(3));
            rv.exp_vc      = -1;
            apply_stimulus(rv);
        end

        // Reset in the middle of a BODY stream must abort at once and leave a clean IDLE.
        @(negedge noc_clk);
        req_valid   = 1'b1;
        req_dst_x   = 4'd3;
        req_dst_y   = 4'd3;
        req_len     = LW'(6);
        tx_vc_ready = 4'b1111;
        tx_ready    = 4'b1111;
        pay_valid   = 1'b1;
        pay_data    = $urandom;
        #1;
        check_output("rst_seq_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge noc_clk);
            req_valid = 1'b0;
            pay_data  = $urandom;
        end
        #1;
        check_output("rst_seq_mid_valid", |tx_valid, 1'b1);
        check_output("rst_seq_mid_busy", busy, 1'b1);
        noc_rst_n = 1'b0;
        #1;
        check_output("rst_async_tx_valid", tx_valid, '0);
        check_output("rst_async_busy", busy, 1'b0);
        pay_valid = 1'b0;
        tx_ready  = '0;
        repeat (2) @(negedge noc_clk);
        noc_rst_n = 1'b1;
        #1;
        model_ptr = 0;
        check_output("rst_release_req_ready", req_ready, 1'b1);
        check_output("rst_release_pay_ready", pay_ready, 1'b0);
        check_output("rst_release_tx_flit", tx_flit, '0);
        apply_stimulus(tbl[10]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
